bitrev_reorder: RTL and testbench

BITREV_REORDER -- requirements
Module: bitrev_reorder

---
 rtl/bitrev_reorder.sv | 119 +++++++++++
 tb/tb_bitrev_reorder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bitrev_reorder.sv
// Bit-reversed to natural-order frame reorder buffer with ping-pong banks.
// Optional macro BITREV_REORDER_IDX_EN adds the o_idx bin-index output.
module bitrev_reorder #(
  parameter int W     = 11,
  parameter int LOG2N = 8
) (
  input  logic                 mclk,
  input  logic                 i_init_n,
  input  logic                 i_vld,
  input  logic signed [W-1:0]  i_I,
  input  logic signed [W-1:0]  i_Q,
  output logic                 o_vld,
  output logic signed [W-1:0]  o_I,
  output logic signed [W-1:0]  o_Q,
`ifdef BITREV_REORDER_IDX_EN
  output logic [LOG2N-1:0]     o_idx,
`endif
  output logic                 o_sof
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  logic [2*W-1:0]   r_mem [2*N];
  logic [LOG2N-1:0] r_wcnt;
  logic [LOG2N-1:0] r_rcnt;
  logic             r_bank;
  state_t           r_state;

  logic             w_acc;
  logic             w_last;
  logic [LOG2N:0]   w_waddr;
  logic [LOG2N:0]   w_raddr;

  function automatic logic [LOG2N-1:0] f_bitrev(
    input logic [LOG2N-1:0] a
  );
    logic [LOG2N-1:0] r;
    r = '0;
    for (int k = 0; k < LOG2N; k++) begin
      r[k] = a[LOG2N-1-k];
    end
    return r;
  endfunction

  // Reset masks i_vld; bank r_bank is written, ~r_bank is read.
  assign w_acc   = i_init_n & i_vld;
  assign w_last  = w_acc && (r_wcnt == LAST);
  assign w_waddr = {r_bank, f_bitrev(r_wcnt)};
  assign w_raddr = {~r_bank, r_rcnt};

  // Writer: counts accepted samples and flips banks on frame end.
  always_ff @(posedge mclk) begin
    if (!i_init_n) begin
      r_wcnt <= '0;
      r_bank <= 1'b0;
    end else if (w_acc) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (w_last) begin
        r_bank <= ~r_bank;
      end
    end
  end

  // Sample storage, scattered to bit-reversed addresses; never cleared.
  always_ff @(posedge mclk) begin
    if (w_acc) begin
      r_mem[w_waddr] <= {i_I, i_Q};
    end
  end

  // Reader FSM: sweeps the filled bank and registers the output.
  always_ff @(posedge mclk) begin
    if (!i_init_n) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
      o_vld   <= 1'b0;
      o_sof   <= 1'b0;
      o_I     <= '0;
      o_Q     <= '0;
`ifdef BITREV_REORDER_IDX_EN
      o_idx   <= '0;
`endif
    end else begin
      o_vld <= 1'b0;
      o_sof <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_last) begin
            r_state <= S_READ;
            r_rcnt  <= '0;
          end
        end
        S_READ: begin
          o_vld      <= 1'b1;
          o_sof      <= (r_rcnt == '0);
          {o_I, o_Q} <= r_mem[w_raddr];
`ifdef BITREV_REORDER_IDX_EN
          o_idx      <= r_rcnt;
`endif
          if (w_last) begin
            r_rcnt <= '0;
          end else if (r_rcnt == LAST) begin
            r_state <= S_IDLE;
            r_rcnt  <= '0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder with LOG2N=3, W=11.
// Checks o_idx too when built with BITREV_REORDER_IDX_EN.
module tb_bitrev_reorder;

  localparam int W     = 11;
  localparam int LOG2N = 3;

  logic                mclk;
  logic                i_init_n;
  logic                i_vld;
  logic signed [W-1:0] i_I;
  logic signed [W-1:0] i_Q;
  logic                o_vld;
  logic signed [W-1:0] o_I;
  logic signed [W-1:0] o_Q;
  logic                o_sof;
`ifdef BITREV_REORDER_IDX_EN
  logic [LOG2N-1:0]    o_idx;
`endif

  int n_chk;
  int n_fail;
  int rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  bitrev_reorder #(.W(W), .LOG2N(LOG2N)) dut (
    .mclk     (mclk),
    .i_init_n (i_init_n),
    .i_vld    (i_vld),
    .i_I      (i_I),
    .i_Q      (i_Q),
    .o_vld    (o_vld),
    .o_I      (o_I),
    .o_Q      (o_Q),
`ifdef BITREV_REORDER_IDX_EN
    .o_idx    (o_idx),
`endif
    .o_sof    (o_sof)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic drive(input logic v, input int val);
    i_vld = v;
    i_I   = W'(val);
    i_Q   = W'(-val);
  endtask

  task automatic chk_out(input string tag, input int val,
                         input logic sof, input int idx);
    logic signed [W-1:0] eI;
    logic signed [W-1:0] eQ;
    eI = W'(val);
    eQ = W'(-val);
    chk({tag, ".vld"}, 32'(o_vld), 32'(1'b1));
    chk({tag, ".I"}, 32'(o_I), 32'(eI));
    chk({tag, ".Q"}, 32'(o_Q), 32'(eQ));
    chk({tag, ".sof"}, 32'(o_sof), 32'(sof));
`ifdef BITREV_REORDER_IDX_EN
    chk({tag, ".idx"}, 32'(o_idx), 32'(idx));
`else
    if (idx < 0) $display("unused idx");
`endif
  endtask

  task automatic chk_frame(input string tag, input int base);
    for (int j = 0; j < 8; j++) begin
      step();
      chk_out(tag, base + rev[j], (j == 0), j);
    end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    i_init_n = 1'b0;
    drive(1'b0, 0);

    // Reset state
    step();
    step();
    chk("rst.vld", 32'(o_vld), 32'd0);
    chk("rst.I", 32'(o_I), 32'd0);
    chk("rst.Q", 32'(o_Q), 32'd0);
    chk("rst.sof", 32'(o_sof), 32'd0);
`ifdef BITREV_REORDER_IDX_EN
    chk("rst.idx", 32'(o_idx), 32'd0);
`endif
    i_init_n = 1'b1;

    // Single frame, I=0..7, Q=-I
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k);
      step();
      chk("s1.in_vld", 32'(o_vld), 32'd0);
    end
    drive(1'b0, 0);
    chk_frame("s1", 0);
    step();
    chk("s1.tail_vld", 32'(o_vld), 32'd0);
    chk("s1.hold_I", 32'(o_I), 32'(W'(7)));
    chk("s1.hold_sof", 32'(o_sof), 32'd0);

    // Gappy input, invalid cycles carry junk
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k);
      step();
      drive(1'b0, 99);
      if (k != 7) begin
        step();
        chk("s2.gap_vld", 32'(o_vld), 32'd0);
      end
    end
    chk("s2.t1_vld", 32'(o_vld), 32'd0);
    chk_frame("s2", 0);
    step();
    chk("s2.tail_vld", 32'(o_vld), 32'd0);

    // Back-to-back frames, I=0..23
    for (int c = 0; c < 34; c++) begin
      if (c < 24) drive(1'b1, c);
      else drive(1'b0, 0);
      step();
      if (c >= 8 && c < 32) begin
        chk_out("s3", ((c - 8) / 8) * 8 + rev[(c - 8) % 8],
                ((c - 8) % 8) == 0, (c - 8) % 8);
      end else begin
        chk("s3.idle_vld", 32'(o_vld), 32'd0);
      end
    end

    // Reset mid-input
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 50 + k);
      step();
    end
    i_init_n = 1'b0;
    drive(1'b1, 77);
    step();
    i_init_n = 1'b1;
    chk("s4.rst_vld", 32'(o_vld), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 100 + k);
      step();
      chk("s4.in_vld", 32'(o_vld), 32'd0);
    end
    drive(1'b0, 0);
    chk_frame("s4", 100);
    step();
    chk("s4.tail_vld", 32'(o_vld), 32'd0);

    // Reset during third output cycle
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 200 + k);
      step();
    end
    drive(1'b0, 0);
    step();
    chk_out("s5.o0", 200, 1'b1, 0);
    step();
    chk_out("s5.o1", 204, 1'b0, 1);
    step();
    chk_out("s5.o2", 202, 1'b0, 2);
    i_init_n = 1'b0;
    step();
    i_init_n = 1'b1;
    chk("s5.rst_vld", 32'(o_vld), 32'd0);
    chk("s5.rst_I", 32'(o_I), 32'd0);
    chk("s5.rst_sof", 32'(o_sof), 32'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("s5.quiet_vld", 32'(o_vld), 32'd0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
